// File: rtl/sseg_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: segment codes, converter states, BCD helper.
// Segment codes are active-low, bit order g..a.
package sseg_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [15:0] BCD_MAX   = 16'd9999;

    // One double-dabble correction step: add 3 to every BCD digit that is 5 or more.
    function automatic logic [15:0] dabble(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/sseg4_scan_bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// Handshake: start is accepted only in IDLE; busy is high from the cycle after start until done; done pulses one cycle with bcd/overflow valid.
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        overflow
);

    conv_state_t state, state_next;
    logic [15:0] sh;
    logic [15:0] acc;
    logic [3:0]  cnt;
    logic        ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CONV_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            CONV_IDLE: begin
                if (start) state_next = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                busy = 1'b1;
                if (cnt == 4'd15) state_next = CONV_DONE;
            end
            CONV_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = CONV_IDLE;
            end
            default: state_next = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == CONV_IDLE && start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= '0;
            ovf <= (bin > BCD_MAX);
        end else if (state == CONV_SHIFT) begin
            {acc, sh} <= {dabble(acc), sh} << 1;
            cnt       <= cnt + 4'd1;
        end
    end

    assign bcd      = acc;
    assign overflow = ovf;

endmodule

// File: rtl/sseg4_scan.sv
// Four-digit multiplexed seven-segment driver, hex or decimal (0..9999, dashes above).
// Build option SSEG_LEADING_ZERO_BLANK_EN blanks leading zeros in decimal mode.
module sseg4_scan
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        hex_mode,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

    logic [19:0] refresh_cnt;
    logic [1:0]  idx;
    logic [15:0] lat_value;
    logic        lat_hex;
    logic        conv_start, conv_busy, conv_done, conv_ovf;
    logic [15:0] conv_bcd;
    logic [15:0] disp;
    logic        disp_ovf;
    logic        disp_dec;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 20'd1;
        end
    end

    // A change seen mid-conversion waits for the converter to return to IDLE.
    assign conv_start = !hex_mode && !conv_busy && ((value != lat_value) || lat_hex);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_value <= '0;
            lat_hex   <= 1'b0;
        end else if (hex_mode) begin
            lat_value <= value;
            lat_hex   <= 1'b1;
        end else if (conv_start) begin
            lat_value <= value;
            lat_hex   <= 1'b0;
        end
    end

    bin2bcd_seq u_conv (
        .clk      (clk),
        .reset    (reset),
        .start    (conv_start),
        .bin      (value),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp     <= '0;
            disp_ovf <= 1'b0;
            disp_dec <= 1'b0;
        end else if (hex_mode) begin
            disp     <= value;
            disp_ovf <= 1'b0;
            disp_dec <= 1'b0;
        end else if (conv_done) begin
            disp     <= conv_bcd;
            disp_ovf <= conv_ovf;
            disp_dec <= 1'b1;
        end
    end

    assign digit = disp[{idx, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (disp_dec && !disp_ovf) begin
            case (idx)
                2'd3:    blank = (disp[15:12] == 4'd0);
                2'd2:    blank = (disp[15:8] == 8'd0);
                2'd1:    blank = (disp[15:4] == 12'd0);
                default: blank = 1'b0;
            endcase
        end
`endif
    end

    always_comb begin
        seg_next = SEG_TABLE[digit];
        if (disp_dec && disp_ovf) seg_next = SEG_DASH;
        else if (blank)           seg_next = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
            dp  <= ~dp_in[idx];
        end
    end

endmodule

// File: tb/tb_sseg4_scan.sv
// Directed self-checking bench for sseg4_scan with REFRESH_DIV = 4.
// Expected leading-zero codes follow SSEG_LEADING_ZERO_BLANK_EN when defined.
module tb_sseg4_scan;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        hex_mode;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks;
    int n_fails;
    logic [6:0] exp_q[$];

    // hand-written active-low g..a codes
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S7 = 7'h78, SC = 7'h46, SD = 7'h21, SE = 7'h06;
    localparam logic [6:0] SDASH = 7'h3F, SBLANK = 7'h7F;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SBLANK;
`else
    localparam logic [6:0] LZ = S0;
`endif

    sseg4_scan #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .hex_mode (hex_mode),
        .dp_in    (dp_in),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int an_to_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return 0;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] v, input logic hm, input logic [3:0] dpi);
        value    = v;
        hex_mode = hm;
        dp_in    = dpi;
    endtask

    task automatic capture(output logic [27:0] segs, output logic [3:0] dps);
        logic [3:0] seen;
        seen = 4'h0;
        segs = '0;
        dps  = '0;
        for (int c = 0; c < 48 && seen != 4'hF; c++) begin
            @(negedge clk);
            if (an == 4'b1110 || an == 4'b1101 || an == 4'b1011 || an == 4'b0111) begin
                segs[an_to_idx(an)*7 +: 7] = seg;
                dps[an_to_idx(an)]         = dp;
                seen[an_to_idx(an)]        = 1'b1;
            end
        end
        if (seen != 4'hF) check("capture_timeout", seen, 4'hF);
    endtask

    // digit 3 first, digit 0 last
    task automatic expect_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                                 input logic [6:0] d1, input logic [6:0] d0);
        logic [27:0] segs;
        logic [3:0]  dps;
        exp_q.push_back(d3);
        exp_q.push_back(d2);
        exp_q.push_back(d1);
        exp_q.push_back(d0);
        capture(segs, dps);
        for (int i = 3; i >= 0; i--) check(tag, segs[i*7 +: 7], exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] pat [4];
        logic [6:0] old_codes [4];
        logic [6:0] c42 [4];
        logic [6:0] c77 [4];
        int stray;
        int ix;

        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        drive(16'd0, 1'b0, 4'b0000);
        cycles(3);
        check("reset_an", an, 4'b1111);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);

        // reset pulse mid-scan
        reset = 1'b0;
        cycles(7);
        #2 reset = 1'b1;
        #1;
        check("midreset_an", an, 4'b1111);
        check("midreset_seg", seg, 7'h7F);
        check("midreset_dp", dp, 1'b1);
        cycles(2);
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check("an_seq", an, pat[(k / 4) % 4]);
        end

        // hex mode
        drive(16'hC0DE, 1'b1, 4'b0000);
        cycles(2);
        expect_digits("hex_c0de", SC, S0, SD, SE);
        drive(16'h0007, 1'b1, 4'b0000);
        cycles(2);
        expect_digits("hex_0007", S0, S0, S0, S7);

        // decimal 1234: old display held for 17 cycles
        old_codes = '{S7, S0, S0, S0};
        drive(16'd1234, 1'b0, 4'b0000);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("dec_hold_old", seg, old_codes[an_to_idx(an)]);
        end
        cycles(4);
        expect_digits("dec_1234", S1, S2, S3, S4);

        drive(16'd10000, 1'b0, 4'b0000);
        cycles(20);
        expect_digits("dec_dashes", SDASH, SDASH, SDASH, SDASH);

        // 42 -> 77 changed during shift
        c42 = '{S2, S4, LZ, LZ};
        c77 = '{S7, S7, LZ, LZ};
        stray = 0;
        drive(16'd42, 1'b0, 4'b0000);
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 4) value = 16'd77;
            ix = an_to_idx(an);
            if (k >= 19 && k <= 34) check("hold_42", seg, c42[ix]);
            else if (seg != SDASH && seg != c42[ix] && seg != c77[ix]) stray++;
        end
        check("no_partial", stray, 0);
        expect_digits("dec_77", LZ, LZ, S7, S7);

        // decimal point on digit 2
        dp_in = 4'b0100;
        cycles(2);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("dp_digit2", dp, (an == 4'b1011) ? 1'b0 : 1'b1);
        end
        dp_in = 4'b0000;

        // leading zeros
        drive(16'd7, 1'b0, 4'b0000);
        cycles(20);
        expect_digits("dec_7", LZ, LZ, LZ, S7);
        drive(16'd0, 1'b0, 4'b0000);
        cycles(20);
        expect_digits("dec_0", LZ, LZ, LZ, S0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sseg4_scan.md
SSEG4_SCAN -- requirements
Module: sseg4_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port value, input, 16 bits: number to display.
REQ-005 The block SHALL have port hex_mode, input, 1 bit: 1 = four hex digits of value; 0 = decimal 0..9999.
REQ-006 The block SHALL have port dp_in, input, 4 bits: decimal point request per digit, bit i = digit i (digit 0 rightmost).
REQ-007 The block SHALL have port seg, output, 7 bits: segments g..a, active-low.
REQ-008 The block SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-009 The block SHALL have port an, output, 4 bits: digit anodes, active-low, one-hot-low while scanning.

Function
REQ-010 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-011 an SHALL be the complement of (1 << index); seg/dp SHALL show the display-register nibble and dp_in bit for that index, all registered (one cycle after index changes).
REQ-012 Hex mode: display register SHALL load value[15:0] nibbles one cycle after value or hex_mode is sampled changed.
REQ-013 Decimal mode: a converter FSM SHALL run IDLE -> SHIFT (16 double-dabble shift cycles on latched value) -> DONE (one cycle, loads display register) -> IDLE; input-to-display latency 18 cycles.
REQ-014 Converter SHALL restart from IDLE whenever value or hex_mode differs from the latched copy; a change during SHIFT SHALL be ignored until DONE, then a new conversion SHALL start next cycle; the display register SHALL never hold a partial result.
REQ-015 Decimal mode with value > 9999 SHALL display four dashes (segment g only) with dp_in still honoured.
REQ-016 Segment codes SHALL be standard 0-9, A, b, C, d, E, F.
REQ-017 Switching hex_mode SHALL take effect at the display register without disturbing scan index or refresh counter.

Reset
REQ-018 While reset is high: an = 4'b1111, seg = 7'b1111111, dp = 1, index = 0, counter = 0, converter = IDLE, display register = 0.
REQ-019 Reset asserted mid-conversion SHALL abort to IDLE immediately; first cycle after release SHALL drive an = 4'b1110.

Configuration
REQ-020 Macro SSEG_LEADING_ZERO_BLANK_EN defined: in decimal mode, leading zero digits above the most significant nonzero digit SHALL be blanked (seg = 7'b1111111; anode still scanned; dp still honoured); digit 0 is never blanked.
REQ-021 Macro undefined: all four digits SHALL always be shown, including leading zeros; hex mode never blanks in either case.

Structure
REQ-022 Package sseg_pkg SHALL hold the 16-entry segment code table, dash and blank constants, and the converter state enum.
REQ-023 Converter SHALL be sub-module bin2bcd_seq (clk, reset, start, bin[15:0], busy, done, bcd[15:0], overflow); scan and encode stay in sseg4_scan.

Verification (REFRESH_DIV = 4)
REQ-024 Reset pulse mid-scan -> outputs all 1s during reset; after release an sequence 1110,1101,1011,0111 each held exactly 4 cycles, repeating.
REQ-025 hex_mode=1, value=16'hC0DE -> digits 3..0 show C,0,d,E within one cycle.
REQ-026 hex_mode=0, value=1234 -> display unchanged for 17 cycles, then 1,2,3,4; value=10000 -> four dashes.
REQ-027 hex_mode=0, value changed 42->77 at SHIFT cycle 5 -> 42 displayed, then 77; no intermediate values.
REQ-028 dp_in=4'b0100 -> dp low only while an=1011.
REQ-029 With SSEG_LEADING_ZERO_BLANK_EN, decimal value=7 -> digits 3..1 blank, digit 0 shows 7; without it -> 0,0,0,7; value=0 -> digit 0 shows 0 in both builds.
